pipeline_hazard_controller: RTL
===============================

# pipeline_hazard_controller

Central hazard sequencer for the 5-stage RV32 pipeline. Each cycle it resolves load-use stalls, EX-stage branch redirects, and instruction/data-memory wait states into per-stage write-enable, flush and forwarding-select controls. A wait-state FSM freezes the pipeline during data-memory stalls and traps a memory watchdog timeout. It sits beside the pipeline registers and drives their enables directly.

## Interface
- `MAX_WAIT`, 64: dmem wait cycles tolerated before timeout.
- `CNT_W`, 32: width of the performance counters.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each  ID-stage source registers.
- `id_use_rs1`, `id_use_rs2`  in  1 each  the ID instruction reads that source.
- `ex_rs1`, `ex_rs2`  in  5 each  EX-stage source registers.
- `ex_rd`  in  5  EX-stage destination.
- `ex_mem_read`  in  1  EX instruction is a load.
- `mem_rd`  in  5  MEM destination.
- `mem_reg_write`  in  1  MEM writes the register file.
- `wb_rd`  in  5  WB destination.
- `wb_reg_write`  in  1  WB writes the register file.
- `branch_taken`  in  1  EX resolved a taken branch or jump.
- `imem_busy`  in  1  instruction fetch not complete.
- `dmem_busy`  in  1  data access not complete.
- `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write`, `mem_wb_write`  out  1 each  stage register enables.
- `if_id_flush`, `id_ex_flush`  out  1 each  load a bubble into that register.
- `fwd_rs1_sel`, `fwd_rs2_sel`  out  2 each  00 regfile, 01 from MEM, 10 from WB.
- `mem_timeout`  out  1  sticky watchdog error.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  saturating event counters.

## Operation
- **Register x0.** Never matches for any hazard or forward comparison.
- **Load-use condition:** `ex_mem_read`, `ex_rd`≠0, and (`ex_rd`==`id_rs1` with `id_use_rs1`) or (`ex_rd`==`id_rs2` with `id_use_rs2`).
- **Forwarding.**
  - Per operand: MEM match with `mem_reg_write` → 01.
  - Otherwise WB match with `wb_reg_write` → 10.
  - Otherwise 00.
  - MEM has priority over WB.
  - Purely combinational. Valid in every state.
- **FSM states:** RUN, DWAIT, ERROR.
- **RUN**, events in priority order:
  1. `dmem_busy`: all five enables = 0, no flush, next state DWAIT, wait_cnt ← 1.
  2. `branch_taken`: all enables = 1, `if_id_flush` = `id_ex_flush` = 1.
  3. load-use: `pc_write` = `if_id_write` = 0, `id_ex_flush` = 1, other enables = 1.
  4. `imem_busy`: `pc_write` = 0, `if_id_flush` = 1, other enables = 1.
  5. None: all enables = 1, no flush.
- **DWAIT.**
  - While `dmem_busy`: everything frozen; wait_cnt increments.
  - When wait_cnt reaches MAX_WAIT with `dmem_busy` still high: next state ERROR.
  - When `dmem_busy` = 0 in DWAIT: outputs evaluated exactly as RUN priorities 2–5 in that same cycle; next state RUN.
- **ERROR.** All enables = 0, no flush, `mem_timeout` = 1. Left only by reset.
- **`stall_cnt`** increments on any cycle where `pc_write` = 0 outside ERROR.
- **`flush_cnt`** increments on any cycle where any flush = 1.
- Both counters saturate at all-ones.
- **Reset** is asynchronous and overrides everything, including mid-DWAIT:
  - state RUN, wait_cnt 0, counters 0, `mem_timeout` 0.
  - While `reset` is high: all enables 0, both flushes 1, fwd selects 00.

## Timing
- Enables, flushes and fwd selects are combinational from state and inputs: zero-cycle latency, Mealy.
- State, wait_cnt, counters and `mem_timeout` update on the rising edge of `clk`.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM and the condition clears by itself; the dependent instruction then takes the WB forward (10) in EX.
- Branch concurrent with load-use: the branch wins; the flush removes the dependent instruction.
- Branch arriving during DWAIT is held by the frozen EX register. It is serviced on the exit cycle.
- Timeout: the edge at which `dmem_busy` has been high for MAX_WAIT consecutive DWAIT cycles sets ERROR. `mem_timeout` is visible the following cycle.

## Structure
- Package `hazard_ctrl_pkg` holds:
  - state enum (RUN = 0, DWAIT = 1, ERROR = 2);
  - FWD_REG = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10.
- Sub-module `forward_select`, one comparator/priority unit per operand, instantiated twice.
- Everything else lives in the top module.

## Test plan
- Load x5 in EX, ID reads x5 as rs1:
  - `pc_write` = `if_id_write` = 0, `id_ex_flush` = 1 for one cycle.
  - Next cycle `fwd_rs1_sel` = 10.
- `ex_rs2` = 7, `mem_rd` = 7, `wb_rd` = 7, both write enables high → `fwd_rs2_sel` = 01. Set `mem_rd` = 0 → 10.
- Load to x0 with a matching ID source → no stall.
- `branch_taken` together with load-use → both flushes 1, `pc_write` = 1, `flush_cnt` +1.
- `dmem_busy` high for 3 cycles with MAX_WAIT = 64:
  - all enables 0 for 3 cycles, `stall_cnt` = 3;
  - RUN on the 4th cycle.
- `dmem_busy` held high beyond MAX_WAIT = 4 → `mem_timeout` = 1 and stays 1. Asserting `reset` mid-DWAIT clears the state, counters and `mem_timeout` immediately.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    ERROR = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Register-number match that never fires on x0.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_forward_select.sv
// Per-operand forwarding priority unit: MEM result beats WB result beats regfile.
module forward_select
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_reg_write_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_reg_write_i,
  output logic [1:0] sel_o
);

  // Pick the youngest in-flight producer of rs_i.
  always_comb begin
    sel_o = FWD_REG;
    if (mem_reg_write_i && reg_match(mem_rd_i, rs_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_reg_write_i && reg_match(wb_rd_i, rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central hazard sequencer: stage enables, flushes, forwarding selects,
// dmem wait-state FSM with watchdog, and saturating stall/flush counters.
module pipeline_hazard_controller
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             branch_taken,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WC_W = $clog2(MAX_WAIT + 1);

  state_e             state_q, state_d;
  logic [WC_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic               load_use;
  logic               service;
  logic [1:0]         fwd_rs1_raw, fwd_rs2_raw;

  forward_select u_fwd_rs1 (
    .rs_i            (ex_rs1),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .sel_o           (fwd_rs1_raw)
  );

  forward_select u_fwd_rs2 (
    .rs_i            (ex_rs2),
    .mem_rd_i        (mem_rd),
    .mem_reg_write_i (mem_reg_write),
    .wb_rd_i         (wb_rd),
    .wb_reg_write_i  (wb_reg_write),
    .sel_o           (fwd_rs2_raw)
  );

  assign load_use = ex_mem_read &&
                    ((id_use_rs1 && reg_match(ex_rd, id_rs1)) ||
                     (id_use_rs2 && reg_match(ex_rd, id_rs2)));

  assign fwd_rs1_sel = reset ? FWD_REG : fwd_rs1_raw;
  assign fwd_rs2_sel = reset ? FWD_REG : fwd_rs2_raw;
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  // Wait-state FSM next state plus Mealy enables/flushes.
  // The DWAIT exit cycle shares the RUN priority chain through 'service'.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    service      = 1'b0;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_write  = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_write = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;

    case (state_q)
      RUN: begin
        if (dmem_busy) begin
          state_d    = DWAIT;
          wait_cnt_d = WC_W'(1);
        end else begin
          service = 1'b1;
        end
      end
      DWAIT: begin
        if (dmem_busy) begin
          if (wait_cnt_q == WC_W'(MAX_WAIT)) begin
            state_d = ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end else begin
          service    = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      ERROR:   ;
      default: state_d = RUN;
    endcase

    if (service) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '1;
      if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end else if (imem_busy) begin
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
      end
    end

    if (reset) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // Saturating event counters and sticky watchdog flag.
  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    mem_timeout_d = mem_timeout_q | (state_d == ERROR);
    if (!pc_write && state_q != ERROR && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((if_id_flush || id_ex_flush) && flush_cnt_q != '1) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State, wait counter, counters and watchdog flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

endmodule
